// File: rtl/sample_loop_ctrl_if.sv
// BRAM-side bus of the sample record/playback sequencer.
// master = sequencer (drives address/write strobe/write data), slave = sample BRAM.
interface sample_loop_ctrl_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 10
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (output ram_addr, output ram_we, output ram_wdata, input ram_rdata);
    modport slave  (input ram_addr, input ram_we, input ram_wdata, output ram_rdata);
endinterface

// File: rtl/sample_loop_ctrl.sv
// Record/playback sequencer in front of the sample BRAM.
// Records one sample per sample_tick, then plays the take back through the
// BRAM's 1-cycle synchronous read port, optionally looping at the end of take.
module sample_loop_ctrl #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              sample_tick,
    input  logic              rec_req,
    input  logic              play_req,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [DATA_W-1:0] sample_in,
    sample_loop_ctrl_if.master ram,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_valid,
    output logic [ADDR_W:0]   rec_len,
    output logic              busy,
    output logic              full,
    output logic              overrun
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RECORD    = 3'd1;
    localparam logic [2:0] S_PLAY_WAIT = 3'd2;
    localparam logic [2:0] S_PLAY_ADDR = 3'd3;
    localparam logic [2:0] S_PLAY_DATA = 3'd4;

    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_last;

    // Last sample of the take is the one at rec_len-1 (rec_len is never 0 while playing).
    assign rd_last = ({1'b0, rd_ptr} == (rec_len - LEN_ONE));
    assign busy    = (state != S_IDLE);

    // Sequencer: priority stop > rec_req > play_req > sample_tick in every state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state            <= S_IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            rec_len          <= '0;
            ram.ram_addr     <= '0;
            ram.ram_we       <= 1'b0;
            ram.ram_wdata    <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            full             <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            ram.ram_we       <= 1'b0;
            sample_out_valid <= 1'b0;
            full             <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!stop) begin
                        if (rec_req) begin
                            state   <= S_RECORD;
                            wr_ptr  <= '0;
                            rec_len <= '0;
                        end else if (play_req && (rec_len != '0)) begin
                            state   <= S_PLAY_WAIT;
                            rd_ptr  <= '0;
                            overrun <= 1'b0;
                        end
                    end
                end
                S_RECORD: begin
                    if (stop) begin
                        // A tick coinciding with stop is deliberately not written.
                        state <= S_IDLE;
                    end else if (sample_tick) begin
                        ram.ram_addr  <= wr_ptr;
                        ram.ram_wdata <= sample_in;
                        ram.ram_we    <= 1'b1;
                        wr_ptr        <= wr_ptr + PTR_ONE;
                        rec_len       <= {1'b0, wr_ptr} + LEN_ONE;
                        // Memory full: end the take here rather than wrapping over it.
                        if (wr_ptr == LAST_ADDR) begin
                            full  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_PLAY_WAIT: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (sample_tick) begin
                        ram.ram_addr <= rd_ptr;
                        state        <= S_PLAY_ADDR;
                    end
                end
                S_PLAY_ADDR: begin
                    // BRAM registers read data on this edge.
                    if (stop) begin
                        state <= S_IDLE;
                    end else begin
                        if (sample_tick) overrun <= 1'b1;
                        state <= S_PLAY_DATA;
                    end
                end
                S_PLAY_DATA: begin
                    if (stop) begin
                        // In-flight read is dropped without a valid pulse.
                        state <= S_IDLE;
                    end else begin
                        if (sample_tick) overrun <= 1'b1;
                        sample_out       <= ram.ram_rdata;
                        sample_out_valid <= 1'b1;
                        if (rd_last) begin
                            rd_ptr <= '0;
                            state  <= loop_en ? S_PLAY_WAIT : S_IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + PTR_ONE;
                            state  <= S_PLAY_WAIT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_loop_ctrl.sv
// Bench for sample_loop_ctrl: a full-depth instance with a BRAM model and a
// 16-deep instance (shared stimulus) used for the memory-full case.
module tb_sample_loop_ctrl;
    localparam int AW  = 18;
    localparam int AW2 = 4;
    localparam int DW  = 10;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    logic          sample_tick = 1'b0, rec_req = 1'b0, play_req = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [DW-1:0] sample_in = '0;

    logic [DW-1:0] sample_out, sample_out2;
    logic          sample_out_valid, sample_out_valid2;
    logic [AW:0]   rec_len;
    logic [AW2:0]  rec_len2;
    logic          busy, busy2, full, full2, overrun, overrun2;

    sample_loop_ctrl_if #(.ADDR_W(AW),  .DATA_W(DW)) bus ();
    sample_loop_ctrl_if #(.ADDR_W(AW2), .DATA_W(DW)) bus2 ();

    sample_loop_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .sample_tick(sample_tick), .rec_req(rec_req),
        .play_req(play_req), .stop(stop), .loop_en(loop_en), .sample_in(sample_in),
        .ram(bus.master), .sample_out(sample_out), .sample_out_valid(sample_out_valid),
        .rec_len(rec_len), .busy(busy), .full(full), .overrun(overrun)
    );

    sample_loop_ctrl #(.ADDR_W(AW2), .DATA_W(DW)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .sample_tick(sample_tick), .rec_req(rec_req),
        .play_req(play_req), .stop(stop), .loop_en(loop_en), .sample_in(sample_in),
        .ram(bus2.master), .sample_out(sample_out2), .sample_out_valid(sample_out_valid2),
        .rec_len(rec_len2), .busy(busy2), .full(full2), .overrun(overrun2)
    );

    // Sample BRAM: write-enable port and 1-cycle synchronous read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge Clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end
    assign bus2.ram_rdata = '0;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Observed activity, logged mid-cycle.
    int wa[$], wd[$], oval[$], ocyc[$], w2a[$];
    int full1_cnt = 0, full2_cnt = 0;
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (bus.ram_we) begin
                wa.push_back(int'(bus.ram_addr));
                wd.push_back(int'(bus.ram_wdata));
            end
            if (sample_out_valid) begin
                oval.push_back(int'(sample_out));
                ocyc.push_back(cyc);
            end
            if (bus2.ram_we) w2a.push_back(int'(bus2.ram_addr));
            if (full)  full1_cnt++;
            if (full2) full2_cnt++;
        end
    end

    // Reference state: the take as written, tick cycles, expected playback.
    int take[$], tq[$], expq[$];
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic cyc_n(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); oval.delete(); ocyc.delete(); tq.delete(); w2a.delete();
    endtask

    task automatic pulse_rec();  rec_req = 1'b1;  cyc_n(1); rec_req = 1'b0;  endtask
    task automatic pulse_play(); play_req = 1'b1; cyc_n(1); play_req = 1'b0; endtask
    task automatic pulse_stop(); stop = 1'b1;     cyc_n(1); stop = 1'b0;     endtask

    // One tick carrying d, occupying gap cycles in total.
    task automatic tick(input int d, input int gap);
        sample_in   = DW'(d);
        sample_tick = 1'b1;
        tq.push_back(cyc);
        cyc_n(1);
        sample_tick = 1'b0;
        if (gap > 1) cyc_n(gap - 1);
    endtask

    // Record n samples (random or 1..n), then stop.
    task automatic rec_take(input int n, input int gapmax, input bit rnd);
        int d;
        clear_logs();
        take.delete();
        pulse_rec();
        for (int i = 0; i < n; i++) begin
            d = rnd ? int'($urandom_range(0, (1 << DW) - 1)) : i + 1;
            take.push_back(d);
            tick(d, int'($urandom_range(1, gapmax)));
        end
        pulse_stop();
        cyc_n(2);
    endtask

    task automatic check_rec(input string tag);
        chk({tag, " writes"}, wa.size(), take.size());
        for (int i = 0; i < take.size() && i < wa.size(); i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), wa[i], i);
            chk($sformatf("%s wdata[%0d]", tag, i), wd[i], take[i]);
        end
        chk({tag, " rec_len"}, int'(rec_len), take.size());
        chk({tag, " busy"}, int'(busy), 0);
    endtask

    // Playback model: tick k plays take[k mod len] when looping, otherwise
    // take[k] for the first len ticks and nothing afterwards.
    function automatic void build_expect(input int nt, input bit lp);
        expq.delete();
        for (int k = 0; k < nt; k++) begin
            if (lp) expq.push_back(take[k % take.size()]);
            else if (k < take.size()) expq.push_back(take[k]);
        end
    endfunction

    task automatic play_seq(input string tag, input int nt, input bit lp, input int gmin, input int gmax);
        clear_logs();
        loop_en = lp;
        pulse_play();
        for (int k = 0; k < nt; k++) tick(int'($urandom_range(0, 1023)), int'($urandom_range(gmin, gmax)));
        cyc_n(5);
        chk({tag, " busy"}, int'(busy), (!lp && nt >= take.size()) ? 0 : 1);
        pulse_stop();
        cyc_n(2);
        build_expect(nt, lp);
        chk({tag, " count"}, oval.size(), expq.size());
        for (int i = 0; i < expq.size() && i < oval.size(); i++) begin
            chk($sformatf("%s data[%0d]", tag, i), oval[i], expq[i]);
            chk($sformatf("%s lat[%0d]", tag, i), ocyc[i] - tq[i], 3);
        end
        chk({tag, " idle"}, int'(busy), 0);
    endtask

    typedef struct {
        logic rec;
        logic play;
        logic stp;
        int   exp_busy;
        int   exp_len;
    } vec_t;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int   n, nt;
        bit   lp;
        // Request decoding in IDLE with a 3-sample take stored.
        vt[0] = '{1'b0, 1'b0, 1'b0, 0, 3};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1, 3};
        vt[2] = '{1'b0, 1'b1, 1'b1, 0, 3};
        vt[3] = '{1'b1, 1'b1, 1'b1, 0, 3};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1, 0};
        vt[5] = '{1'b0, 1'b1, 1'b0, 0, 0};

        // Reset state
        cyc_n(2);
        chk("rst ram_we", int'(bus.ram_we), 0);
        chk("rst ram_addr", int'(bus.ram_addr), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst rec_len", int'(rec_len), 0);
        chk("rst valid", int'(sample_out_valid), 0);
        @(negedge Clk) Reset_n = 1'b1;
        cyc_n(2);

        // Record 0x001..0x005
        rec_take(5, 2, 1'b0);
        check_rec("rec5");

        // Play without loop, extra tick after the take is ignored
        play_seq("play5", 6, 1'b0, 4, 4);

        // Loop: 12 ticks over a 5-sample take
        play_seq("loop12", 12, 1'b1, 4, 4);

        // Tick during PLAY_ADDR is dropped and flagged
        clear_logs();
        loop_en = 1'b1;
        pulse_play();
        tick(0, 1);
        tick(0, 1);
        cyc_n(5);
        chk("ovr flag", int'(overrun), 1);
        chk("ovr outputs", oval.size(), 1);
        if (oval.size() > 0) chk("ovr data", oval[0], take[0]);
        pulse_stop();
        cyc_n(1);
        pulse_play();
        chk("ovr clear on play", int'(overrun), 0);
        pulse_stop();
        cyc_n(1);

        // Stop during PLAY_ADDR drops the read
        clear_logs();
        pulse_play();
        tick(0, 1);
        pulse_stop();
        cyc_n(5);
        chk("stop play outputs", oval.size(), 0);
        chk("stop play busy", int'(busy), 0);

        // Randomized record/playback against the model
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(1, 40));
            rec_take(n, 3, 1'b1);
            check_rec($sformatf("rnd%0d rec", it));
            lp = 1'(($urandom & 1));
            nt = int'($urandom_range(1, 2 * n + 2));
            play_seq($sformatf("rnd%0d play", it), nt, lp, 3, 5);
        end

        // Stop coincident with a tick in RECORD writes nothing
        clear_logs();
        take.delete();
        pulse_rec();
        for (int i = 0; i < 3; i++) begin
            take.push_back(16 + i);
            tick(16 + i, 2);
        end
        sample_in = DW'(99);
        sample_tick = 1'b1;
        stop = 1'b1;
        cyc_n(1);
        sample_tick = 1'b0;
        stop = 1'b0;
        cyc_n(3);
        check_rec("stop+tick");

        // IDLE request table
        for (int i = 0; i < 6; i++) begin
            rec_req = vt[i].rec;
            play_req = vt[i].play;
            stop = vt[i].stp;
            cyc_n(1);
            rec_req = 1'b0;
            play_req = 1'b0;
            stop = 1'b0;
            chk($sformatf("tbl%0d busy", i), int'(busy), vt[i].exp_busy);
            chk($sformatf("tbl%0d rec_len", i), int'(rec_len), vt[i].exp_len);
            pulse_stop();
            cyc_n(1);
        end

        // Full: 16-deep instance, 20 back-to-back ticks
        clear_logs();
        full2_cnt = 0;
        pulse_rec();
        for (int i = 0; i < 20; i++) tick(i, 1);
        cyc_n(3);
        chk("full writes", w2a.size(), 16);
        for (int i = 0; i < 16 && i < w2a.size(); i++) chk($sformatf("full addr[%0d]", i), w2a[i], i);
        chk("full pulses", full2_cnt, 1);
        chk("full rec_len", int'(rec_len2), 16);
        chk("full busy", int'(busy2), 0);
        chk("deep no full", full1_cnt, 0);
        pulse_stop();
        cyc_n(1);

        // Asynchronous reset in the middle of a write cycle
        pulse_rec();
        tick(7, 1);
        chk("pre-rst we", int'(bus.ram_we), 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst we", int'(bus.ram_we), 0);
        chk("arst addr", int'(bus.ram_addr), 0);
        chk("arst wdata", int'(bus.ram_wdata), 0);
        chk("arst sample_out", int'(sample_out), 0);
        chk("arst valid", int'(sample_out_valid), 0);
        chk("arst rec_len", int'(rec_len), 0);
        chk("arst busy", int'(busy), 0);
        chk("arst full", int'(full), 0);
        chk("arst overrun", int'(overrun), 0);
        @(negedge Clk) Reset_n = 1'b1;
        cyc_n(2);
        chk("post-rst busy", int'(busy), 0);
        chk("post-rst rec_len", int'(rec_len), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
